// File: rtl/ripple_carry_adder_pipeline_2_pkg.sv
// Shared definitions for the two-stage pipelined ripple-carry adder.
//   fa_eval : 1-bit full-adder equation, returns {carry_out, sum}.
package ripple_carry_adder_pipeline_2_pkg;

  localparam int PIPE_STAGES = 2;

  // Plain ripple cell: no generate/propagate lookahead.
  function automatic logic [1:0] fa_eval(input logic x, input logic y, input logic c);
    logic p;
    p = x ^ y;
    return {(x & y) | (c & p), p ^ c};
  endfunction

endpackage

// File: rtl/ripple_carry_adder_pipeline_2_ripple_adder.sv
// Ripple-carry building blocks.
//   full_adder   : x, y, ci -> s, co (1 bit)
//   ripple_adder : x[W-1:0] + y[W-1:0] + ci -> s[W-1:0], co; a chain of W full_adders
module full_adder
  import ripple_carry_adder_pipeline_2_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign {co, s} = fa_eval(x, y, ci);
endmodule

module ripple_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  // c[i] is the carry into bit i; c[W] leaves the chain.
  logic [W:0] c;
  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[W];
endmodule

// File: rtl/ripple_carry_adder_pipeline_2.sv
// Two-stage pipelined ripple-carry adder: {cout, sum} = a + b + cin.
// Stage 1 adds the lower half and registers it along with the upper operands
// and the mid carry; stage 2 adds the upper half and registers the result.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every pipeline register
//   a, b : Nbits operands (Nbits even, >= 2)
//   cin  : carry into bit 0
//   sum  : registered sum, valid 2 edges after the operands are sampled
//   cout : registered carry out of bit Nbits-1
module ripple_carry_adder_pipeline_2 #(
  parameter int Nbits = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Nbits-1:0] a,
  input  logic [Nbits-1:0] b,
  input  logic             cin,
  output logic [Nbits-1:0] sum,
  output logic             cout
);
  localparam int L = Nbits / 2;
  localparam int H = Nbits - L;

  // stage 1
  logic [L-1:0] lo_sum;
  logic         c_mid;
  logic [L-1:0] lo_sum_r;
  logic         c_mid_r;
  logic [H-1:0] a_hi_r, b_hi_r;

  // stage 2
  logic [H-1:0] hi_sum;
  logic         hi_co;

  ripple_adder #(.W(L)) u_lo (
    .x  (a[L-1:0]),
    .y  (b[L-1:0]),
    .ci (cin),
    .s  (lo_sum),
    .co (c_mid)
  );

  ripple_adder #(.W(H)) u_hi (
    .x  (a_hi_r),
    .y  (b_hi_r),
    .ci (c_mid_r),
    .s  (hi_sum),
    .co (hi_co)
  );

  // Reset clears both stages together, so in-flight work is dropped and the
  // cycle after reset still reads 0 (stage 2 adds the cleared stage 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_sum_r <= '0;
      c_mid_r  <= 1'b0;
      a_hi_r   <= '0;
      b_hi_r   <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      lo_sum_r <= lo_sum;
      c_mid_r  <= c_mid;
      a_hi_r   <= a[Nbits-1:L];
      b_hi_r   <= b[Nbits-1:L];
      sum      <= {hi_sum, lo_sum_r};
      cout     <= hi_co;
    end
  end
endmodule

// File: tb/tb_ripple_carry_adder_pipeline_2.sv
module tb_ripple_carry_adder_pipeline_2;
  localparam int NB = 64;
  localparam int NTP = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] a, b;
  logic          cin;
  logic [NB-1:0] sum;
  logic          cout;

  int ncmp = 0;
  int nbad = 0;

  ripple_carry_adder_pipeline_2 #(.Nbits(NB)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          cin;
    logic [NB-1:0] es;
    logic          ec;
  } vec_t;

  task automatic chk(input string nm, input logic [NB-1:0] es, input logic ec);
    ncmp++;
    if (sum !== es || cout !== ec) begin
      nbad++;
      $display("FAIL %s: got cout=%0b sum=%h, want cout=%0b sum=%h", nm, cout, sum, ec, es);
    end
  endtask

  task automatic drive(input logic [NB-1:0] ta, input logic [NB-1:0] tb_, input logic tc);
    a = ta; b = tb_; cin = tc;
  endtask

  vec_t vt[11];
  logic [NB-1:0] ta[NTP], tbv[NTP];
  logic          tc[NTP];
  logic [NB:0]   ref_v;

  initial begin
    vt[0]  = '{64'h1, 64'h1, 1'b0, 64'h2, 1'b0};
    vt[1]  = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
    vt[2]  = '{64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[3]  = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
    vt[5]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
    vt[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vt[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    vt[8]  = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0};
    vt[9]  = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 64'h0, 1'b1};
    vt[10] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};

    // reset with nonzero inputs held for 2 edges
    rst = 1'b1;
    drive(64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset", 64'h0, 1'b0);
    rst = 1'b0;

    // table: each vector isolated, checked 2 edges after capture
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].a, vt[i].b, vt[i].cin);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vt[i].es, vt[i].ec);
    end

    // back-to-back: 1+1 then a c_mid carry
    @(negedge clk); drive(64'h1, 64'h1, 1'b0);
    @(negedge clk); drive(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    @(negedge clk); drive(64'h0, 64'h0, 1'b0);
    chk("b2b_0", 64'h2, 1'b0);
    @(negedge clk);
    chk("b2b_1", 64'h0000_0001_0000_0000, 1'b0);

    // mid-stream reset discards the in-flight pair, then pipeline resumes
    @(negedge clk); drive(64'h1111, 64'h2222, 1'b0);
    @(negedge clk); drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 1'b0); rst = 1'b1;
    @(negedge clk);
    chk("midrst_now", 64'h0, 1'b0);
    rst = 1'b0;
    drive(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b1);
    @(negedge clk);
    chk("midrst_flush", 64'h0, 1'b0);
    @(negedge clk);
    chk("after_rst", 64'h0000_0001_0000_0001, 1'b0);

    // throughput: consecutive random operands vs 2-cycle-delayed model
    for (int i = 0; i < NTP; i++) begin
      ta[i]  = {$urandom, $urandom};
      tbv[i] = {$urandom, $urandom};
      tc[i]  = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < NTP + 2; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        ref_v = {1'b0, ta[n-2]} + {1'b0, tbv[n-2]} + {{NB{1'b0}}, tc[n-2]};
        chk($sformatf("rand%0d", n - 2), ref_v[NB-1:0], ref_v[NB]);
      end
      if (n < NTP) drive(ta[n], tbv[n], tc[n]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
